time_counter: RTL and testbench

TIME_COUNTER -- requirements
Module: time_counter

---
 rtl/time_counter.sv | 182 ++++++++++++++++++
 tb/tb_time_counter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/time_counter.sv
// Real-time clock counter: HH:MM:SS in packed BCD, advanced by rising edges of a 1 Hz level,
// with a handshake-driven time load that is range-checked before it is applied.
module time_counter #(
  parameter int HOURS_24 = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_div,
  input  logic       run,
  input  logic       set_valid,
  output logic       set_ready,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic [7:0] set_ss,
  input  logic       set_pm,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       pm,
  output logic       sec_pulse,
  output logic       day_pulse,
  output logic       set_err
);

  typedef enum logic [1:0] {S_RUN, S_CHECK, S_APPLY} state_t;

  localparam logic [7:0] HH_RESET = (HOURS_24 != 0) ? 8'h00 : 8'h12;

  state_t     r_state, w_state_nxt;
  logic       r_clk_div_q;
  logic [7:0] r_hh, r_mm, r_ss;
  logic       r_pm, r_sec_pulse, r_day_pulse, r_set_err, r_set_ready;
  logic [7:0] r_cap_hh, r_cap_mm, r_cap_ss;
  logic       r_cap_pm;

  logic       w_tick, w_accept, w_do_inc, w_do_load, w_set_err_nxt, w_load_ok;
  logic [8:0] w_ss_inc, w_mm_inc;
  logic [7:0] w_hh_inc;
  logic       w_pm_inc, w_day;

  // {wrap, value}: one BCD step of a 00..59 field.
  function automatic logic [8:0] inc59(input logic [7:0] v);
    logic [8:0] r;
    r = {1'b0, v};
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      if (v[7:4] == 4'd5) begin
        r[7:4] = 4'd0;
        r[8]   = 1'b1;
      end else begin
        r[7:4] = v[7:4] + 4'd1;
      end
    end else begin
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction

  function automatic logic [7:0] inc_bcd(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign w_tick = clk_div && !r_clk_div_q;

  always_comb begin
    w_ss_inc = inc59(r_ss);
    w_mm_inc = inc59(r_mm);
    w_hh_inc = inc_bcd(r_hh);
    w_pm_inc = r_pm;
    w_day    = 1'b0;
    if (HOURS_24 != 0) begin
      if (r_hh == 8'h23) begin
        w_hh_inc = 8'h00;
        w_day    = 1'b1;
      end
    end else if (r_hh == 8'h12) begin
      w_hh_inc = 8'h01;
    end else if (r_hh == 8'h11) begin
      w_hh_inc = 8'h12;
      w_pm_inc = !r_pm;
      w_day    = r_pm;
    end
  end

  always_comb begin
    w_load_ok = (r_cap_hh[3:0] <= 4'd9) && (r_cap_hh[7:4] <= 4'd9) &&
                (r_cap_mm[3:0] <= 4'd9) && (r_cap_mm[7:4] <= 4'd5) &&
                (r_cap_ss[3:0] <= 4'd9) && (r_cap_ss[7:4] <= 4'd5);
    if (HOURS_24 != 0) w_load_ok = w_load_ok && (r_cap_hh <= 8'h23);
    else               w_load_ok = w_load_ok && (r_cap_hh >= 8'h01) && (r_cap_hh <= 8'h12);
  end

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_do_inc      = 1'b0;
    w_do_load     = 1'b0;
    w_set_err_nxt = 1'b0;
    case (r_state)
      S_RUN: begin
        if (set_valid && r_set_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_CHECK;
        end else if (w_tick && run) begin
          w_do_inc = 1'b1;
        end
      end
      S_CHECK: begin
        if (w_load_ok) begin
          w_state_nxt = S_APPLY;
        end else begin
          w_state_nxt   = S_RUN;
          w_set_err_nxt = 1'b1;
        end
      end
      S_APPLY: begin
        w_do_load   = 1'b1;
        w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_clk_div_q <= 1'b1;
      r_hh        <= HH_RESET;
      r_mm        <= 8'h00;
      r_ss        <= 8'h00;
      r_pm        <= 1'b0;
      r_sec_pulse <= 1'b0;
      r_day_pulse <= 1'b0;
      r_set_err   <= 1'b0;
      r_set_ready <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_clk_div_q <= clk_div;
      r_sec_pulse <= w_do_inc;
      r_day_pulse <= w_do_inc && w_ss_inc[8] && w_mm_inc[8] && w_day;
      r_set_err   <= w_set_err_nxt;
      r_set_ready <= (w_state_nxt == S_RUN);
      if (w_do_load) begin
        r_hh <= r_cap_hh;
        r_mm <= r_cap_mm;
        r_ss <= r_cap_ss;
        r_pm <= (HOURS_24 == 0) && r_cap_pm;
      end else if (w_do_inc) begin
        r_ss <= w_ss_inc[7:0];
        if (w_ss_inc[8]) begin
          r_mm <= w_mm_inc[7:0];
          if (w_mm_inc[8]) begin
            r_hh <= w_hh_inc;
            r_pm <= w_pm_inc;
          end
        end
      end
    end
  end

  // NOTE: the capture registers carry no reset; they are only read in CHECK/APPLY after a fresh capture.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_cap_hh <= set_hh;
      r_cap_mm <= set_mm;
      r_cap_ss <= set_ss;
      r_cap_pm <= set_pm;
    end
  end

  assign hh        = r_hh;
  assign mm        = r_mm;
  assign ss        = r_ss;
  assign pm        = r_pm;
  assign sec_pulse = r_sec_pulse;
  assign day_pulse = r_day_pulse;
  assign set_err   = r_set_err;
  assign set_ready = r_set_ready;

endmodule

// File: tb/tb_time_counter.sv
// Directed bench for time_counter: one 24-hour and one 12-hour instance share all stimulus,
// and each scenario checks the instance whose hour format it targets.
module tb_time_counter;

  logic       clk, rst, clk_div, run, set_valid, set_pm;
  logic [7:0] set_hh, set_mm, set_ss;

  logic       a_ready, a_pm, a_sec, a_day, a_err;
  logic [7:0] a_hh, a_mm, a_ss;
  logic       b_ready, b_pm, b_sec, b_day, b_err;
  logic [7:0] b_hh, b_mm, b_ss;

  int n_checks = 0;
  int n_errors = 0;

  time_counter #(.HOURS_24(1)) dut24 (
    .clk(clk), .rst(rst), .clk_div(clk_div), .run(run),
    .set_valid(set_valid), .set_ready(a_ready),
    .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss), .set_pm(set_pm),
    .hh(a_hh), .mm(a_mm), .ss(a_ss), .pm(a_pm),
    .sec_pulse(a_sec), .day_pulse(a_day), .set_err(a_err)
  );

  time_counter #(.HOURS_24(0)) dut12 (
    .clk(clk), .rst(rst), .clk_div(clk_div), .run(run),
    .set_valid(set_valid), .set_ready(b_ready),
    .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss), .set_pm(set_pm),
    .hh(b_hh), .mm(b_mm), .ss(b_ss), .pm(b_pm),
    .sec_pulse(b_sec), .day_pulse(b_day), .set_err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic div_rise();
    clk_div = 1'b0;
    step(1);
    clk_div = 1'b1;
    step(1);
  endtask

  task automatic present(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input logic p);
    set_hh    = h;
    set_mm    = m;
    set_ss    = s;
    set_pm    = p;
    set_valid = 1'b1;
  endtask

  task automatic load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input logic p);
    present(h, m, s, p);
    step(1);
    set_valid = 1'b0;
    step(3);
  endtask

  initial begin
    rst = 1'b1; clk_div = 1'b1; run = 1'b1; set_valid = 1'b0;
    set_hh = 8'h00; set_mm = 8'h00; set_ss = 8'h00; set_pm = 1'b0;

    // Reset values and release with clk_div already high.
    step(3);
    check("rst_hh24", a_hh, 8'h00);
    check("rst_hh12", b_hh, 8'h12);
    check("rst_mmss", {a_mm, a_ss}, 16'h0000);
    check("rst_pm12", b_pm, 1'b0);
    check("rst_ready", {a_ready, b_ready}, 2'b00);
    check("rst_pulses", {a_sec, a_day, a_err}, 3'b000);
    rst = 1'b0;
    step(1);
    check("ready_after_rst", {a_ready, b_ready}, 2'b11);
    step(3);
    check("no_tick_high_div", {a_ss, 7'd0, a_sec}, {8'h00, 8'h00});
    clk_div = 1'b0;
    step(1);
    check("no_tick_fall", a_ss, 8'h00);
    clk_div = 1'b1;
    step(1);
    check("first_tick_ss", a_ss, 8'h01);
    check("first_tick_pulse", a_sec, 1'b1);
    step(1);
    check("pulse_one_cycle", a_sec, 1'b0);
    check("ss_hold", a_ss, 8'h01);

    // 24-hour day rollover.
    load(8'h23, 8'h59, 8'h58, 1'b0);
    check("load_235958", {a_hh, a_mm, a_ss}, 24'h235958);
    check("load_no_pulse", {a_sec, a_day}, 2'b00);
    div_rise();
    check("to_235959", {a_hh, a_mm, a_ss}, 24'h235959);
    check("no_day_early", a_day, 1'b0);
    div_rise();
    check("wrap_000000", {a_hh, a_mm, a_ss}, 24'h000000);
    check("day_pulse", a_day, 1'b1);
    step(1);
    check("day_pulse_one", a_day, 1'b0);

    // 12-hour: noon sets pm, midnight clears it with a day pulse.
    load(8'h11, 8'h59, 8'h59, 1'b0);
    check("load12_am", {b_hh, b_mm, b_ss, 7'd0, b_pm}, {24'h115959, 8'h00});
    div_rise();
    check("noon", {b_hh, b_mm, b_ss, 7'd0, b_pm}, {24'h120000, 8'h01});
    check("noon_no_day", b_day, 1'b0);
    check("24h_at_12", {a_hh, a_mm, a_ss, 7'd0, a_pm}, {24'h120000, 8'h00});
    load(8'h11, 8'h59, 8'h59, 1'b1);
    check("load12_pm", b_pm, 1'b1);
    div_rise();
    check("midnight", {b_hh, b_mm, b_ss, 7'd0, b_pm}, {24'h120000, 8'h00});
    check("midnight_day", b_day, 1'b1);
    step(1);
    check("midnight_day_one", b_day, 1'b0);
    load(8'h12, 8'h59, 8'h59, 1'b0);
    div_rise();
    check("12_to_01", {b_hh, b_mm, b_ss, 7'd0, b_pm}, {24'h010000, 8'h00});
    check("24h_12_to_13", {a_hh, a_mm, a_ss}, 24'h130000);

    // Rejected loads: bad minutes, bad hour digit, format-specific hour limits.
    present(8'h10, 8'h60, 8'h00, 1'b0);
    step(1);
    set_valid = 1'b0;
    check("bad_mm_busy", {a_ready, a_err}, 2'b00);
    step(1);
    check("bad_mm_err", {a_err, b_err}, 2'b11);
    check("bad_mm_ready", {a_ready, b_ready}, 2'b11);
    check("bad_mm_keep24", {a_hh, a_mm, a_ss}, 24'h130000);
    check("bad_mm_keep12", {b_hh, b_mm, b_ss}, 24'h010000);
    step(1);
    check("err_one_cycle", {a_err, b_err}, 2'b00);

    present(8'h1A, 8'h00, 8'h00, 1'b0);
    step(1);
    set_valid = 1'b0;
    step(1);
    check("bad_hh_err", {a_err, b_err}, 2'b11);
    check("bad_hh_ready", a_ready, 1'b1);
    step(1);
    check("bad_hh_keep24", {a_hh, a_mm, a_ss}, 24'h130000);

    present(8'h24, 8'h00, 8'h00, 1'b0);
    step(1);
    set_valid = 1'b0;
    step(1);
    check("hh24_limit_err", a_err, 1'b1);
    step(1);

    present(8'h00, 8'h00, 8'h00, 1'b0);
    step(1);
    set_valid = 1'b0;
    step(1);
    check("hh00_12h_err", b_err, 1'b1);
    check("hh00_24h_ok", a_err, 1'b0);
    step(1);
    check("hh00_24h_load", {a_hh, a_mm, a_ss}, 24'h000000);
    check("hh00_12h_keep", {b_hh, b_mm, b_ss}, 24'h010000);
    step(1);

    // Accept wins over a simultaneous tick; run=0 freezes the time.
    clk_div = 1'b0;
    step(1);
    present(8'h10, 8'h00, 8'h00, 1'b0);
    clk_div = 1'b1;
    step(1);
    set_valid = 1'b0;
    check("accept_drops_tick", {a_sec, b_sec}, 2'b00);
    step(3);
    check("load_10_24", {a_hh, a_mm, a_ss}, 24'h100000);
    check("load_10_12", {b_hh, b_mm, b_ss}, 24'h100000);
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      div_rise();
      check("frozen_pulse", a_sec, 1'b0);
    end
    check("frozen_time", {a_hh, a_mm, a_ss}, 24'h100000);
    run = 1'b1;
    div_rise();
    check("resume_tick", {a_hh, a_mm, a_ss, 7'd0, a_sec}, {24'h100001, 8'h01});

    // Reset while a load sits in CHECK.
    present(8'h05, 8'h05, 8'h05, 1'b0);
    step(1);
    set_valid = 1'b0;
    check("in_check_busy", a_ready, 1'b0);
    rst = 1'b1;
    step(1);
    check("mid_rst_ready", {a_ready, b_ready}, 2'b00);
    check("mid_rst_time24", {a_hh, a_mm, a_ss}, 24'h000000);
    rst = 1'b0;
    step(1);
    check("mid_rst_release", a_ready, 1'b1);
    step(2);
    check("load_aborted24", {a_hh, a_mm, a_ss}, 24'h000000);
    check("load_aborted12", {b_hh, b_mm, b_ss, 7'd0, b_pm}, {24'h120000, 8'h00});
    check("aborted_no_err", {a_err, b_err}, 2'b00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
